// File: rtl/digit_frame_streamer.sv
// rtl/digit_frame_streamer.sv - buffers a 16x16 binary frame, streams it to the digit engine and decodes its one-hot result
// Optional WAIT-state watchdog is built only when STREAMER_TIMEOUT_EN is defined.
module digit_frame_streamer #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_row,
  output logic        wr_err,
  input  logic        start,
  output logic        busy,
  output logic [15:0] eng_data_in,
  output logic        eng_data_read,
  input  logic        eng_valid,
  input  logic [9:0]  eng_data_out,
  output logic [3:0]  digit,
  output logic        digit_ok,
  output logic        result_valid,
  output logic        timeout
);

  if (TIMEOUT_CYCLES < 1 || GAP_CYCLES < 0) begin : g_bad_param
    $error("digit_frame_streamer: TIMEOUT_CYCLES must be >= 1 and GAP_CYCLES >= 0");
  end

  typedef enum logic [2:0] {IDLE, PRE, SEND, LAST, WAIT, GAP} state_t;

  state_t      state;
  logic [15:0] frame [16];
  logic [3:0]  row_cnt;
  logic [15:0] gap_cnt;
  logic [4:0]  dec;
`ifdef STREAMER_TIMEOUT_EN
  logic [31:0] wd_cnt;
`endif

  // {ok, digit}: any code that is not exactly one-hot decodes to {0, 4'hF}
  function automatic logic [4:0] decode(input logic [9:0] code);
    logic [3:0] d;
    int         n;
    d = 4'hF;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (code[i]) begin
        n++;
        d = 4'(9 - i);
      end
    end
    return (n == 1) ? {1'b1, d} : {1'b0, 4'hF};
  endfunction

  assign dec = decode(eng_data_out);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      row_cnt       <= '0;
      gap_cnt       <= '0;
      for (int i = 0; i < 16; i++) frame[i] <= '0;
      wr_err        <= 1'b0;
      busy          <= 1'b0;
      eng_data_in   <= '0;
      eng_data_read <= 1'b0;
      digit         <= 4'hF;
      digit_ok      <= 1'b0;
      result_valid  <= 1'b0;
      timeout       <= 1'b0;
`ifdef STREAMER_TIMEOUT_EN
      wd_cnt        <= '0;
`endif
    end else begin
      wr_err       <= 1'b0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;

      // A write in the same cycle as start still lands before row 0 is read
      if (wr_en) begin
        if (state == IDLE) frame[wr_addr] <= wr_row;
        else               wr_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= PRE;
            busy  <= 1'b1;
          end
        end
        PRE: begin
          eng_data_read <= 1'b1;
          eng_data_in   <= '0;
          row_cnt       <= '0;
          state         <= SEND;
        end
        SEND: begin
          eng_data_read <= 1'b1;
          eng_data_in   <= frame[row_cnt];
          if (row_cnt == 4'd14) state <= LAST;
          else                  row_cnt <= row_cnt + 4'd1;
        end
        LAST: begin
          eng_data_read <= 1'b0;
          eng_data_in   <= frame[4'd15];
          row_cnt       <= '0;
          state         <= WAIT;
`ifdef STREAMER_TIMEOUT_EN
          wd_cnt        <= '0;
`endif
        end
        WAIT: begin
          eng_data_in <= '0;
          if (eng_valid) begin
            digit        <= dec[3:0];
            digit_ok     <= dec[4];
            result_valid <= 1'b1;
            gap_cnt      <= '0;
            state        <= GAP;
          end
`ifdef STREAMER_TIMEOUT_EN
          else if (wd_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            digit        <= 4'hF;
            digit_ok     <= 1'b0;
            result_valid <= 1'b1;
            timeout      <= 1'b1;
            gap_cnt      <= '0;
            state        <= GAP;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
`endif
        end
        GAP: begin
          if (({16'd0, gap_cnt} + 32'd1) >= 32'(GAP_CYCLES)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_frame_streamer.sv
// tb/tb_digit_frame_streamer.sv - self-checking bench for digit_frame_streamer (table vectors, random frames, corner sequences)
module tb_digit_frame_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_row = '0;
  logic        wr_err;
  logic        start = 1'b0;
  logic        busy;
  logic [15:0] eng_data_in;
  logic        eng_data_read;
  logic        eng_valid = 1'b0;
  logic [9:0]  eng_data_out = '0;
  logic [3:0]  digit;
  logic        digit_ok;
  logic        result_valid;
  logic        timeout;

`ifdef STREAMER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO_CYC = 16;

  int checks = 0;
  int failures = 0;
  logic [15:0] model_buf [16];
  logic [3:0]  prev_digit = 4'hF;
  logic        prev_ok = 1'b0;

  typedef struct {
    logic [9:0] code;
    logic [3:0] exp_digit;
    logic       exp_ok;
  } vec_t;
  vec_t tbl [13];

  digit_frame_streamer #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_row(wr_row),
    .wr_err(wr_err), .start(start), .busy(busy), .eng_data_in(eng_data_in),
    .eng_data_read(eng_data_read), .eng_valid(eng_valid), .eng_data_out(eng_data_out),
    .digit(digit), .digit_ok(digit_ok), .result_valid(result_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference decode from the rule: one-hot bit k means digit 9-k
  function automatic logic [4:0] ref_decode(input logic [9:0] c);
    if ($countones(c) == 1) return {1'b1, 4'(9 - $clog2(c))};
    return {1'b0, 4'hF};
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, " data_in"}, 32'(eng_data_in), 32'd0);
    chk({tag, " data_read"}, 32'(eng_data_read), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " wr_err"}, 32'(wr_err), 32'd0);
    chk({tag, " digit"}, 32'(digit), 32'hF);
    chk({tag, " digit_ok"}, 32'(digit_ok), 32'd0);
    chk({tag, " result_valid"}, 32'(result_valid), 32'd0);
    chk({tag, " timeout"}, 32'(timeout), 32'd0);
  endtask

  task automatic write_row(input logic [3:0] a, input logic [15:0] r);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_row = r;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    chk("idle write wr_err", 32'(wr_err), 32'd0);
    model_buf[a] = r;
  endtask

  // Starts a frame from a negedge, checks streaming/wait/gap timing, returns the decoded result
  task automatic do_frame(input logic [9:0] code, input int dly, input bit respond,
                          input bit inject_wr, input bit wr_with_start, input logic [15:0] start_row,
                          output logic [3:0] d, output logic ok);
    logic [15:0] exp_rows [16];
    logic [15:0] exp_data;
    bit          got_rv;
    bit          exp_rv;
    int          rd_cnt;
    d = 4'hF; ok = 1'b0; got_rv = 0; rd_cnt = 0;
    start = 1'b1;
    if (wr_with_start) begin
      wr_en = 1'b1; wr_addr = 4'd0; wr_row = start_row;
      model_buf[0] = start_row;
    end
    exp_rows = model_buf;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    chk("E0 busy", 32'(busy), 32'd1);
    chk("E0 data_read", 32'(eng_data_read), 32'd0);
    for (int cyc = 1; cyc <= 17; cyc++) begin
      eng_valid = (cyc == 3);
      eng_data_out = 10'h200;
      if (inject_wr && cyc == 5) begin
        wr_en = 1'b1; wr_addr = 4'd3; wr_row = 16'hFFFF;
      end
      @(posedge clk);
      @(negedge clk);
      eng_valid = 1'b0; wr_en = 1'b0;
      exp_data = (cyc == 1) ? 16'h0 : exp_rows[cyc - 2];
      chk($sformatf("stream c%0d data_in", cyc), 32'(eng_data_in), 32'(exp_data));
      chk($sformatf("stream c%0d data_read", cyc), 32'(eng_data_read), 32'(cyc <= 16));
      chk($sformatf("stream c%0d busy", cyc), 32'(busy), 32'd1);
      chk($sformatf("stream c%0d result_valid", cyc), 32'(result_valid), 32'd0);
      chk($sformatf("stream c%0d wr_err", cyc), 32'(wr_err), 32'(inject_wr && cyc == 5));
      chk($sformatf("stream c%0d digit hold", cyc), 32'({digit_ok, digit}), 32'({prev_ok, prev_digit}));
      rd_cnt += int'(eng_data_read);
    end
    for (int w = 1; w <= 40 && !got_rv; w++) begin
      eng_valid = respond && (w == dly);
      eng_data_out = code;
      @(posedge clk);
      @(negedge clk);
      eng_valid = 1'b0;
      exp_rv = respond ? (w == dly) : (TO_EN && w == TO_CYC);
      chk($sformatf("wait w%0d result_valid", w), 32'(result_valid), 32'(exp_rv));
      chk($sformatf("wait w%0d timeout", w), 32'(timeout), 32'(!respond && exp_rv));
      chk($sformatf("wait w%0d data_in", w), 32'(eng_data_in), 32'd0);
      chk($sformatf("wait w%0d busy", w), 32'(busy), 32'd1);
      rd_cnt += int'(eng_data_read);
      if (result_valid) begin
        got_rv = 1; d = digit; ok = digit_ok;
        prev_digit = digit; prev_ok = digit_ok;
      end else begin
        chk($sformatf("wait w%0d digit hold", w), 32'({digit_ok, digit}), 32'({prev_ok, prev_digit}));
      end
    end
    chk("data_read cycle count", 32'(rd_cnt), 32'd16);
    if (got_rv) begin
      @(posedge clk);
      @(negedge clk);
      chk("gap1 result_valid", 32'(result_valid), 32'd0);
      chk("gap1 busy", 32'(busy), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("gap2 busy", 32'(busy), 32'd0);
    end
  endtask

  logic [15:0] glyph [16];
  logic [3:0]  gd;
  logic        gok;
  logic [9:0]  rcode;
  logic [4:0]  rexp;

  initial begin
    glyph = '{16'h07E0, 16'h0FF0, 16'h1C38, 16'h381C, 16'h300C, 16'h700E, 16'h6006, 16'h6006,
              16'h6006, 16'h6006, 16'h700E, 16'h300C, 16'h381C, 16'h1C38, 16'h0FF0, 16'h07E0};
    for (int i = 0; i < 10; i++) tbl[i] = '{10'(10'h200 >> i), 4'(i), 1'b1};
    tbl[10] = '{10'd0, 4'hF, 1'b0};
    tbl[11] = '{10'd3, 4'hF, 1'b0};
    tbl[12] = '{10'h3FF, 4'hF, 1'b0};
    for (int i = 0; i < 16; i++) model_buf[i] = '0;

    repeat (3) @(negedge clk);
    chk_reset("in reset");
    rst = 1'b1;
    @(negedge clk);
    chk_reset("after reset");

    for (int i = 0; i < 16; i++) write_row(4'(i), glyph[i]);
    @(negedge clk);
    do_frame(10'd512, 5, 1, 0, 0, 16'h0, gd, gok);
    chk("glyph0 digit", 32'(gd), 32'd0);
    chk("glyph0 ok", 32'(gok), 32'd1);

    for (int i = 0; i < 13; i++) begin
      do_frame(tbl[i].code, 2, 1, 0, 0, 16'h0, gd, gok);
      chk($sformatf("tbl%0d digit", i), 32'(gd), 32'(tbl[i].exp_digit));
      chk($sformatf("tbl%0d ok", i), 32'(gok), 32'(tbl[i].exp_ok));
    end

    do_frame(10'd4, 3, 1, 1, 0, 16'h0, gd, gok);
    chk("busy-write frame digit", 32'(gd), 32'd7);
    do_frame(10'd64, 1, 1, 0, 0, 16'h0, gd, gok);
    chk("after rejected write digit", 32'(gd), 32'd3);

    do_frame(10'd128, 4, 1, 0, 1, 16'hA5C3, gd, gok);
    chk("write+start digit", 32'(gd), 32'd2);

    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 3; k++) write_row(4'($urandom_range(0, 15)), 16'($urandom));
      @(negedge clk);
      rcode = (n % 2 == 0) ? 10'(10'd1 << $urandom_range(0, 9)) : 10'($urandom);
      rexp = ref_decode(rcode);
      do_frame(rcode, int'($urandom_range(1, 6)), 1, 0, 0, 16'h0, gd, gok);
      chk($sformatf("rand%0d digit", n), 32'(gd), 32'(rexp[3:0]));
      chk($sformatf("rand%0d ok", n), 32'(gok), 32'(rexp[4]));
    end

    for (int i = 0; i < 16; i++) write_row(4'(i), glyph[i]);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("pre-abort row7", 32'(eng_data_in), 32'(model_buf[7]));
    #2 rst = 1'b0;
    #1 chk_reset("mid-stream reset");
    @(negedge clk);
    chk_reset("held reset");
    rst = 1'b1;
    prev_digit = 4'hF; prev_ok = 1'b0;
    for (int i = 0; i < 16; i++) model_buf[i] = '0;
    @(negedge clk);
    do_frame(10'd2, 2, 1, 0, 0, 16'h0, gd, gok);
    chk("zero frame digit", 32'(gd), 32'd8);

    do_frame(10'd1, 1, 0, 0, 0, 16'h0, gd, gok);
    if (TO_EN) begin
      chk("timeout digit", 32'(gd), 32'hF);
      chk("timeout ok", 32'(gok), 32'd0);
    end else begin
      chk("no-watchdog busy held", 32'(busy), 32'd1);
      chk("no-watchdog timeout", 32'(timeout), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global time limit actual=expired required=done");
    $fatal(1, "time limit");
  end

endmodule
